// File: rtl/chebyshev_pkg.sv
// Shared types and default sizing for the Chebyshev evaluator sequencer.
package chebyshev_pkg;

   localparam int DEF_WL      = 8;  // x / result word length
   localparam int DEF_CL      = 8;  // coefficient word length
   localparam int DEF_N_COEFF = 8;  // number of coefficients (order + 1)
   localparam int DEF_AW      = 3;  // coefficient table address width
   localparam int DEF_LAT     = 2;  // evaluator latency in clock edges

   // Sequencer control states
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

endpackage : chebyshev_pkg

// File: rtl/chebyshev_coeff_table.sv
// Coefficient register file: one range-checked write port that is locked
// while an evaluation runs, one combinational read port, sticky error flag.
module chebyshev_coeff_table #(
   parameter int CL      = 8,
   parameter int N_COEFF = 8,
   parameter int AW      = 3
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          i_we,
   input  logic          i_lock,
   input  logic [AW-1:0] i_wr_addr,
   input  logic [CL-1:0] i_wr_data,
   input  logic [AW-1:0] i_rd_addr,
   output logic [CL-1:0] o_rd_data,
   output logic          o_err
);

   localparam int IW = (N_COEFF > 1) ? $clog2(N_COEFF) : 1;

   logic [CL-1:0] r_table [N_COEFF];
   logic          r_err;
   logic          w_in_range;
   logic          w_wr_ok;
   logic          w_wr_bad;

   // Extra top bit keeps the bound representable when N_COEFF == 2**AW.
   assign w_in_range = ({1'b0, i_wr_addr} < (AW+1)'(N_COEFF));
   assign w_wr_ok    = i_we & ~i_lock & w_in_range;
   assign w_wr_bad   = i_we & (i_lock | ~w_in_range);

   // Table storage and sticky illegal-write flag
   // NOTE: this storage is a register file that must read back 0 after reset,
   // so every entry is reset; a RAM macro could not offer that and would be
   // left unreset instead.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < N_COEFF; i++) r_table[i] <= '0;
         r_err <= 1'b0;
      end else begin
         if (w_wr_ok)  r_table[i_wr_addr[IW-1:0]] <= i_wr_data;
         if (w_wr_bad) r_err <= 1'b1;
      end
   end

   assign o_rd_data = r_table[i_rd_addr[IW-1:0]];
   assign o_err     = r_err;

endmodule : chebyshev_coeff_table

// File: rtl/chebyshev_sequencer.sv
// Initiator for the Chebyshev evaluator: streams x with c[N-1]..c[0] on
// start, waits the evaluator latency, captures its result with a valid pulse.
module chebyshev_sequencer
   import chebyshev_pkg::*;
#(
   parameter int WL      = DEF_WL,
   parameter int CL      = DEF_CL,
   parameter int N_COEFF = DEF_N_COEFF,
   parameter int AW      = DEF_AW,
   parameter int LAT     = DEF_LAT
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          cfg_we,
   input  logic [AW-1:0] cfg_addr,
   input  logic [CL-1:0] cfg_wdata,
   output logic          cfg_err,
   input  logic          start,
   input  logic [WL-1:0] x_in,
   output logic          busy,
   output logic          cheb_valid,
   output logic          cheb_first,
   output logic [WL-1:0] cheb_data,
   output logic [CL-1:0] cheb_coeff,
   input  logic [WL-1:0] cheb_result,
   output logic [WL-1:0] result,
   output logic          result_valid
);

   localparam int CW = (LAT > 0) ? $clog2(LAT + 1) : 1;

   state_t        r_state,  w_state_nxt;
   logic [AW-1:0] r_idx,    w_idx_nxt;
   logic [CW-1:0] r_cnt,    w_cnt_nxt;
   logic [WL-1:0] r_x,      w_x_nxt;
   logic          r_valid,  w_valid_nxt;
   logic          r_first,  w_first_nxt;
   logic [WL-1:0] r_data,   w_data_nxt;
   logic [CL-1:0] r_coeff,  w_coeff_nxt;
   logic [WL-1:0] r_result, w_result_nxt;
   logic          r_rvalid, w_rvalid_nxt;
   logic          r_busy,   w_busy_nxt;

   logic [AW-1:0] w_rd_addr;
   logic [CL-1:0] w_rd_data;

   // The next coefficient to present: c[N-1] on start, else one below the current index.
   assign w_rd_addr = (r_state == ST_IDLE) ? AW'(N_COEFF - 1) : (r_idx - AW'(1));

   chebyshev_coeff_table #(
      .CL      (CL),
      .N_COEFF (N_COEFF),
      .AW      (AW)
   ) u_table (
      .clock     (clock),
      .reset     (reset),
      .i_we      (cfg_we),
      .i_lock    (r_busy),
      .i_wr_addr (cfg_addr),
      .i_wr_data (cfg_wdata),
      .i_rd_addr (w_rd_addr),
      .o_rd_data (w_rd_data),
      .o_err     (cfg_err)
   );

   // State, counters and all registered outputs
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state  <= ST_IDLE;
         r_idx    <= '0;
         r_cnt    <= '0;
         r_x      <= '0;
         r_valid  <= 1'b0;
         r_first  <= 1'b0;
         r_data   <= '0;
         r_coeff  <= '0;
         r_result <= '0;
         r_rvalid <= 1'b0;
         r_busy   <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_idx    <= w_idx_nxt;
         r_cnt    <= w_cnt_nxt;
         r_x      <= w_x_nxt;
         r_valid  <= w_valid_nxt;
         r_first  <= w_first_nxt;
         r_data   <= w_data_nxt;
         r_coeff  <= w_coeff_nxt;
         r_result <= w_result_nxt;
         r_rvalid <= w_rvalid_nxt;
         r_busy   <= w_busy_nxt;
      end
   end

   // Next-state and next-output decode
   // NOTE: every signal gets a default before the case so no path leaves one
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      w_state_nxt  = r_state;
      w_idx_nxt    = r_idx;
      w_cnt_nxt    = r_cnt;
      w_x_nxt      = r_x;
      w_valid_nxt  = 1'b0;
      w_first_nxt  = 1'b0;
      w_data_nxt   = '0;
      w_coeff_nxt  = '0;
      w_result_nxt = r_result;
      w_rvalid_nxt = 1'b0;
      w_busy_nxt   = r_busy;

      unique case (r_state)
         ST_IDLE: begin
            w_busy_nxt = 1'b0;
            // A simultaneous table write wins; the start is dropped.
            if (start && !cfg_we) begin
               w_state_nxt = ST_ISSUE;
               w_x_nxt     = x_in;
               w_idx_nxt   = AW'(N_COEFF - 1);
               w_valid_nxt = 1'b1;
               w_first_nxt = 1'b1;
               w_data_nxt  = x_in;
               w_coeff_nxt = w_rd_data;
               w_busy_nxt  = 1'b1;
            end
         end
         ST_ISSUE: begin
            if (r_idx == '0) begin
               w_state_nxt = ST_WAIT;
               w_cnt_nxt   = CW'(LAT);
            end else begin
               w_idx_nxt   = r_idx - AW'(1);
               w_valid_nxt = 1'b1;
               w_data_nxt  = r_x;
               w_coeff_nxt = w_rd_data;
            end
         end
         ST_WAIT: begin
            if (r_cnt <= CW'(1)) begin
               w_state_nxt  = ST_DONE;
               w_result_nxt = cheb_result;
               w_rvalid_nxt = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt - CW'(1);
            end
         end
         ST_DONE: begin
            w_state_nxt = ST_IDLE;
            w_busy_nxt  = 1'b0;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   assign busy         = r_busy;
   assign cheb_valid   = r_valid;
   assign cheb_first   = r_first;
   assign cheb_data    = r_data;
   assign cheb_coeff   = r_coeff;
   assign result       = r_result;
   assign result_valid = r_rvalid;

endmodule : chebyshev_sequencer

// File: tb/tb_chebyshev_sequencer.sv
// Self-checking bench for chebyshev_sequencer (N_COEFF=8, LAT=2, AW=4 so
// out-of-range table addresses are expressible). The evaluator is stubbed.
module tb_chebyshev_sequencer;

   localparam int N   = 8;
   localparam int LAT = 2;
   localparam int NB  = N + LAT + 1;   // busy cycles per evaluation

   logic       clock = 1'b0;
   logic       reset;
   logic       cfg_we, start;
   logic [3:0] cfg_addr;
   logic [7:0] cfg_wdata, x_in, cheb_result;
   logic       cfg_err, busy, cheb_valid, cheb_first, result_valid;
   logic [7:0] cheb_data, cheb_coeff, result;

   int n_total = 0;
   int n_bad   = 0;

   // Reference model state
   logic [7:0] ref_tab [N];
   logic       ref_err;
   logic [7:0] ref_result;

   typedef struct {
      logic       we;
      logic [3:0] addr;
      logic [7:0] data;
      logic       start;
      logic       exp_busy;
      logic       exp_err;
   } vec_t;

   vec_t vecs [10];

   chebyshev_sequencer #(
      .WL(8), .CL(8), .N_COEFF(N), .AW(4), .LAT(LAT)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .cfg_we       (cfg_we),
      .cfg_addr     (cfg_addr),
      .cfg_wdata    (cfg_wdata),
      .cfg_err      (cfg_err),
      .start        (start),
      .x_in         (x_in),
      .busy         (busy),
      .cheb_valid   (cheb_valid),
      .cheb_first   (cheb_first),
      .cheb_data    (cheb_data),
      .cheb_coeff   (cheb_coeff),
      .cheb_result  (cheb_result),
      .result       (result),
      .result_valid (result_valid)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, " busy"},   busy,         0);
      check({tag, " valid"},  cheb_valid,   0);
      check({tag, " first"},  cheb_first,   0);
      check({tag, " data"},   cheb_data,    0);
      check({tag, " coeff"},  cheb_coeff,   0);
      check({tag, " result"}, result,       0);
      check({tag, " rvalid"}, result_valid, 0);
      check({tag, " err"},    cfg_err,      0);
   endtask

   // Apply table vectors lo..hi in IDLE, one per cycle.
   task automatic apply_vecs(input int lo, input int hi);
      for (int i = lo; i <= hi; i++) begin
         cfg_we = vecs[i].we; cfg_addr = vecs[i].addr; cfg_wdata = vecs[i].data;
         start = vecs[i].start; x_in = 8'h11;
         step();
         cfg_we = 1'b0; start = 1'b0;
         if (vecs[i].we && vecs[i].addr < 4'(N)) ref_tab[vecs[i].addr[2:0]] = vecs[i].data;
         if (vecs[i].exp_err) ref_err = 1'b1;
         check($sformatf("vec%0d busy", i),  busy,       vecs[i].exp_busy);
         check($sformatf("vec%0d err", i),   cfg_err,    vecs[i].exp_err);
         check($sformatf("vec%0d valid", i), cheb_valid, 0);
      end
   endtask

   // Full evaluation from IDLE. start_at / we_at (1..NB, 0 = none) inject a
   // start or a table write during busy cycle k.
   task automatic run_eval(input logic [7:0] x, input logic [7:0] stub,
                           input int start_at, input int we_at,
                           input logic [3:0] we_addr, input logic [7:0] we_data);
      logic [7:0] exp_c [N];
      for (int i = 0; i < N; i++) exp_c[i] = ref_tab[i];
      start = 1'b1; x_in = x; cfg_we = 1'b0; cheb_result = ~stub;
      step();                                   // E0
      start = 1'b0;
      for (int k = 1; k <= NB; k++) begin
         check($sformatf("k%0d busy", k),  busy,         1);
         check($sformatf("k%0d valid", k), cheb_valid,   k <= N);
         check($sformatf("k%0d first", k), cheb_first,   k == 1);
         check($sformatf("k%0d data", k),  cheb_data,    (k <= N) ? x : 8'h00);
         check($sformatf("k%0d coeff", k), cheb_coeff,   (k <= N) ? exp_c[N - k] : 8'h00);
         check($sformatf("k%0d rvalid", k), result_valid, k == NB);
         check($sformatf("k%0d result", k), result,      (k == NB) ? stub : ref_result);
         check($sformatf("k%0d err", k),   cfg_err,      ref_err);
         cheb_result = (k == N + LAT) ? stub : ~stub;
         start       = (k == start_at);
         x_in        = 8'($urandom);
         cfg_we      = (k == we_at);
         cfg_addr    = we_addr;
         cfg_wdata   = we_data;
         step();
         if (k == we_at) ref_err = 1'b1;
      end
      start = 1'b0; cfg_we = 1'b0;
      ref_result = stub;
      check("end busy",   busy,         0);
      check("end rvalid", result_valid, 0);
      check("end valid",  cheb_valid,   0);
      check("end result", result,       stub);
   endtask

   initial begin
      reset = 1'b1; cfg_we = 1'b0; start = 1'b0; cfg_addr = '0; cfg_wdata = '0;
      x_in = '0; cheb_result = '0;
      for (int i = 0; i < N; i++) ref_tab[i] = 8'h00;
      ref_err = 1'b0; ref_result = 8'h00;

      for (int i = 0; i < N; i++) vecs[i] = '{1'b1, 4'(i), 8'(i + 1), 1'b0, 1'b0, 1'b0};
      vecs[8] = '{1'b1, 4'd3, 8'h33, 1'b1, 1'b0, 1'b0};   // start+write: write wins
      vecs[9] = '{1'b1, 4'd9, 8'h99, 1'b0, 1'b0, 1'b1};   // out of range

      // Reset state
      step(); step();
      check_all_zero("reset");
      reset = 1'b0;
      step();
      check_all_zero("post-reset");

      // Tests 1/2: table i+1, evaluate x=2B, stub 5A
      apply_vecs(0, N - 1);
      run_eval(8'h2B, 8'h5A, 0, 0, 4'd0, 8'h00);
      // Test 6: restart in the first idle cycle
      run_eval(8'h2B, 8'h5A, 0, 0, 4'd0, 8'h00);

      // Test 4: start with write in IDLE, then out-of-range address
      apply_vecs(8, 9);
      run_eval(8'hC4, 8'h81, 0, 0, 4'd0, 8'h00);

      // Test 3: start and table write while busy are ignored
      run_eval(8'h2B, 8'h3C, 3, 5, 4'd2, 8'h77);
      run_eval(8'h2B, 8'h3D, 0, 0, 4'd0, 8'h00);

      // Test 5: reset during ISSUE after coefficient 5
      start = 1'b1; x_in = 8'h2B;
      step();
      start = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         check($sformatf("rst k%0d coeff", k), cheb_coeff, ref_tab[N - k]);
         if (k < 4) step();
      end
      #2 reset = 1'b1;
      #1 check_all_zero("async reset");
      step();
      reset = 1'b0;
      for (int i = 0; i < N; i++) ref_tab[i] = 8'h00;
      ref_err = 1'b0; ref_result = 8'h00;
      for (int k = 0; k < NB + 1; k++) begin
         check($sformatf("after rst rvalid %0d", k), result_valid, 0);
         check($sformatf("after rst busy %0d", k),   busy,         0);
         step();
      end
      run_eval(8'h2B, 8'h42, 0, 0, 4'd0, 8'h00);   // table reads all zero

      // Randomized evaluations against the model
      for (int r = 0; r < 8; r++) begin
         for (int w = 0; w < 3; w++) begin
            cfg_we = 1'b1;
            cfg_addr = 4'($urandom_range(0, 15));
            cfg_wdata = 8'($urandom);
            step();
            cfg_we = 1'b0;
            if (cfg_addr < 4'(N)) ref_tab[cfg_addr[2:0]] = cfg_wdata;
            else ref_err = 1'b1;
            check($sformatf("rand%0d wr%0d err", r, w), cfg_err, ref_err);
         end
         run_eval(8'($urandom), 8'($urandom), $urandom_range(0, NB), $urandom_range(0, NB),
                  4'($urandom_range(0, 15)), 8'($urandom));
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule : tb_chebyshev_sequencer
